key_sel_gen: RTL and testbench

//  Front-end selector stage feeding the 3-to-8 LED decoder: turns three raw push-buttons

---
 rtl/key_sel_gen_pkg.sv | 12 +
 rtl/key_sel_gen_if.sv | 12 +
 rtl/key_sel_gen_key_filter.sv | 33 +++
 rtl/key_sel_gen.sv | 45 ++++
 tb/tb_key_sel_gen.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/key_sel_gen_pkg.sv
// key_sel_gen_pkg: shared defaults, index type and index step helper for the selector/decoder path
package key_sel_gen_pkg;
    localparam int unsigned CNT_MAX_DEF  = 999_999;
    localparam int unsigned STEP_MAX_DEF = 24_999_999;
    localparam int          IDX_W        = 3;
    typedef logic [IDX_W-1:0] idx_t;
    localparam idx_t IDX_RST = '0;
    // Manual step: up-only +1, down-only -1, both or neither leave the index alone
    function automatic idx_t idx_step(idx_t i, logic up, logic dn);
        return (up && !dn) ? i + idx_t'(1) : ((dn && !up) ? i - idx_t'(1) : i);
    endfunction
endpackage

// File: rtl/key_sel_gen_if.sv
// key_sel_gen_if: raw push-buttons in, registered decoder select and mode out
interface key_sel_gen_if;
    logic key_up;
    logic key_dn;
    logic key_mode;
    logic sel1;
    logic sel2;
    logic sel3;
    logic auto_mode;
    modport master (output key_up, key_dn, key_mode, input sel1, sel2, sel3, auto_mode);
    modport slave  (input key_up, key_dn, key_mode, output sel1, sel2, sel3, auto_mode);
endinterface

// File: rtl/key_sel_gen_key_filter.sv
// key_filter: two-flop synchroniser plus debounce counter, one-cycle flag per stable press
module key_filter
    import key_sel_gen_pkg::*;
#(
    parameter int unsigned CNT_MAX = CNT_MAX_DEF
) (
    input  logic sys_clk,
    input  logic sys_rst_n,
    input  logic key_n,
    output logic flag
);
    localparam int              CNT_W    = $clog2(CNT_MAX);
    localparam logic [CNT_W-1:0] CNT_TOP  = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_FIRE = CNT_W'(CNT_MAX - 2);
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Shift the raw key in, restart the window on any high sample, flag once just before saturation
    always_comb begin
        sync_d = {sync_q[0], key_n};
        cnt_d  = sync_q[1] ? '0 : (cnt_q == CNT_TOP ? cnt_q : cnt_q + CNT_W'(1));
        flag   = !sync_q[1] && (cnt_q == CNT_FIRE);
    end
    // Released-key state on reset so no phantom press appears after release
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync_q <= 2'b11;
            cnt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
        end
    end
endmodule

// File: rtl/key_sel_gen.sv
// key_sel_gen: debounced up/down/mode keys drive a registered 3-bit decoder index with auto-step
module key_sel_gen
    import key_sel_gen_pkg::*;
#(
    parameter int unsigned CNT_MAX  = CNT_MAX_DEF,
    parameter int unsigned STEP_MAX = STEP_MAX_DEF
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    key_sel_gen_if.slave  bus
);
    localparam int               STEP_W   = $clog2(STEP_MAX);
    localparam logic [STEP_W-1:0] STEP_TOP = STEP_W'(STEP_MAX - 1);
    logic up_f, dn_f, mode_f, tick, any_f;
    idx_t idx_q, idx_d;
    logic auto_q, auto_d;
    logic [STEP_W-1:0] step_q, step_d;
    key_filter #(.CNT_MAX(CNT_MAX)) u_up   (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(bus.key_up),   .flag(up_f));
    key_filter #(.CNT_MAX(CNT_MAX)) u_dn   (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(bus.key_dn),   .flag(dn_f));
    key_filter #(.CNT_MAX(CNT_MAX)) u_mode (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .key_n(bus.key_mode), .flag(mode_f));
    // Manual keys win over the auto tick; any key, tick or mode toggle restarts the step period
    always_comb begin
        tick   = auto_q && (step_q == STEP_TOP);
        any_f  = up_f || dn_f;
        idx_d  = any_f ? idx_step(idx_q, up_f, dn_f) : (tick ? idx_q + idx_t'(1) : idx_q);
        auto_d = auto_q ^ mode_f;
        step_d = (!auto_q || mode_f || any_f || tick) ? '0 : step_q + STEP_W'(1);
    end
    // All outputs come straight from these flops
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            idx_q  <= IDX_RST;
            auto_q <= 1'b0;
            step_q <= '0;
        end else begin
            idx_q  <= idx_d;
            auto_q <= auto_d;
            step_q <= step_d;
        end
    end
    assign bus.sel1      = idx_q[2];
    assign bus.sel2      = idx_q[1];
    assign bus.sel3      = idx_q[0];
    assign bus.auto_mode = auto_q;
endmodule

// File: tb/tb_key_sel_gen.sv
// tb_key_sel_gen: directed and random key stimulus checked against a behavioural selector model
module tb_key_sel_gen;
    localparam int CM = 20;
    localparam int SM = 50;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b1;
    key_sel_gen_if bus();
    key_sel_gen #(.CNT_MAX(CM), .STEP_MAX(SM)) dut (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(bus));
    always #5 sys_clk = ~sys_clk;

    int total = 0;
    int passed = 0;
    int m_idx, m_step;
    bit m_auto;
    int m_run [3];
    bit m_s1 [3];
    bit m_s2 [3];

    function automatic void m_reset();
        m_idx = 0;
        m_step = 0;
        m_auto = 0;
        for (int k = 0; k < 3; k++) begin
            m_run[k] = 0;
            m_s1[k] = 1;
            m_s2[k] = 1;
        end
    endfunction

    // One clock of the reference: a press registers when the synchronised key has been low CM-1 samples
    function automatic void m_clock(input bit up, input bit dn, input bit md);
        bit raw [3];
        bit f [3];
        bit tick;
        raw = '{up, dn, md};
        for (int k = 0; k < 3; k++) begin
            m_run[k] = m_s2[k] ? 0 : m_run[k] + 1;
            f[k] = (m_run[k] == CM - 1);
            m_s2[k] = m_s1[k];
            m_s1[k] = raw[k];
        end
        tick = m_auto && (m_step == SM - 1);
        if (f[0] || f[1]) begin
            m_idx = (m_idx + (f[0] ? 1 : 0) - (f[1] ? 1 : 0) + 8) % 8;
            m_step = 0;
        end else if (tick) begin
            m_idx = (m_idx + 1) % 8;
            m_step = 0;
        end else begin
            m_step = m_auto ? m_step + 1 : 0;
        end
        if (f[2]) begin
            m_auto = !m_auto;
            m_step = 0;
        end
    endfunction

    function automatic logic [7:0] cur_sel();
        return {5'b0, bus.sel1, bus.sel2, bus.sel3};
    endfunction

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge sys_clk);
            if (!sys_rst_n) m_reset();
            else m_clock(bus.key_up, bus.key_dn, bus.key_mode);
            @(negedge sys_clk);
            check("cyc_sel", cur_sel(), 8'(m_idx));
            check("cyc_auto", {7'b0, bus.auto_mode}, {7'b0, m_auto});
        end
    endtask

    task automatic keys(input bit u, input bit d, input bit m);
        bus.key_up = u;
        bus.key_dn = d;
        bus.key_mode = m;
    endtask

    task automatic do_reset();
        sys_rst_n = 1'b0;
        cyc(2);
        sys_rst_n = 1'b1;
    endtask

    initial begin
        int v, n;
        m_reset();
        keys(1, 1, 1);
        #1 sys_rst_n = 1'b0;
        cyc(3);
        sys_rst_n = 1'b1;
        check("reset_sel", cur_sel(), 8'd0);
        check("reset_auto", {7'b0, bus.auto_mode}, 8'd0);
        keys(1, 1, 0); cyc(25); keys(1, 1, 1); cyc(70);
        #2 sys_rst_n = 1'b0;
        #1;
        check("async_rst_sel", cur_sel(), 8'd0);
        check("async_rst_auto", {7'b0, bus.auto_mode}, 8'd0);
        m_reset();
        cyc(2);
        sys_rst_n = 1'b1;
        keys(0, 1, 1); cyc(30); keys(1, 1, 1); cyc(5);
        check("rst_then_up", cur_sel(), 8'd1);
        keys(0, 1, 1); cyc(10); keys(1, 1, 1); cyc(2); keys(0, 1, 1); cyc(200); keys(1, 1, 1); cyc(5);
        check("debounce_hold", cur_sel(), 8'd2);
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            keys(0, 1, 1); cyc(25); keys(1, 1, 1); cyc(5);
            check("wrap_up", cur_sel(), 8'(i % 8));
        end
        keys(1, 0, 1); cyc(25); keys(1, 1, 1); cyc(5);
        check("wrap_dn", cur_sel(), 8'd7);
        keys(0, 0, 1); cyc(25); keys(1, 1, 1); cyc(5);
        check("simul_up_dn", cur_sel(), 8'd7);
        keys(1, 1, 0); cyc(25); keys(1, 1, 1); cyc(5);
        check("auto_on", {7'b0, bus.auto_mode}, 8'd1);
        cyc(400);
        check("auto_wrap8", cur_sel(), 8'd7);
        keys(1, 1, 0); cyc(25); keys(1, 1, 1); cyc(5);
        check("auto_off", {7'b0, bus.auto_mode}, 8'd0);
        v = m_idx;
        cyc(500);
        check("frozen", cur_sel(), 8'(v));
        keys(1, 1, 0); cyc(25); keys(1, 1, 1);
        n = 0;
        while (m_step != 29 && n < 200) begin
            cyc(1);
            n++;
        end
        check("step_wait", {7'b0, n < 200}, 8'd1);
        v = m_idx;
        keys(0, 1, 1); cyc(25); keys(1, 1, 1);
        check("collide_once", cur_sel(), 8'((v + 1) % 8));
        cyc(45);
        check("collide_hold", cur_sel(), 8'((v + 1) % 8));
        cyc(1);
        check("collide_next", cur_sel(), 8'((v + 2) % 8));
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(15) == 0) bus.key_up = ~bus.key_up;
            if ($urandom_range(15) == 0) bus.key_dn = ~bus.key_dn;
            if ($urandom_range(31) == 0) bus.key_mode = ~bus.key_mode;
            cyc(1);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
